// File: rtl/mem_uart_master.sv
// CPU-side memory request master: packs one load/store into a channel-0 comm
// message, waits for the 4-byte load reply, and reports completion to the CPU.
module mem_uart_master #(
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_mask,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        send_flag,
  output logic [4:0]  send_length,
  output logic [71:0] send_data,
  input  logic        sendable,
  output logic        recv_flag,
  input  logic [4:0]  recv_length,
  input  logic [71:0] recv_data,
  input  logic        recvable,
  output logic [7:0]  drop_count
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, RESP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_q, wr_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       mask_q, mask_d;
  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic [31:0]      resp_rdata_q, resp_rdata_d;
  logic             resp_err_q, resp_err_d;
  logic             send_flag_q, send_flag_d;
  logic [4:0]       send_length_q, send_length_d;
  logic [71:0]      send_data_q, send_data_d;
  logic             recv_flag_q, recv_flag_d;
  logic [7:0]       drop_count_q, drop_count_d;
  logic             pop, reply_ok;
  logic             unused_recv_hi;

  assign unused_recv_hi = ^recv_data[71:32];

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    wr_d          = wr_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    mask_d        = mask_q;
    send_flag_d   = 1'b0;
    send_length_d = send_length_q;
    send_data_d   = send_data_q;
    resp_valid_d  = 1'b0;
    resp_rdata_d  = resp_rdata_q;
    resp_err_d    = resp_err_q;
    drop_count_d  = drop_count_q;

    // recvable only falls a cycle after our registered pop, so never pop twice in a row
    pop         = recvable && !recv_flag_q;
    reply_ok    = pop && (state_q == WAIT) && (recv_length == 5'd4);
    recv_flag_d = pop;
    if (pop && !reply_ok && (drop_count_q != 8'hFF)) drop_count_d = drop_count_q + 8'd1;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          mask_d  = req_mask;
          state_d = SEND;
        end
      end
      SEND: begin
        if (sendable) begin
          send_flag_d = 1'b1;
          if (wr_q) begin
            send_length_d = 5'd9;
            send_data_d   = {4'h0, mask_q, addr_q, wdata_q};
            resp_rdata_d  = '0;
            resp_err_d    = 1'b0;
            state_d       = RESP;
          end else begin
            send_length_d = 5'd5;
            send_data_d   = {40'h0, addr_q};
            cnt_d         = '0;
            state_d       = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (reply_ok) begin
          resp_rdata_d = recv_data[31:0];
          resp_err_d   = 1'b0;
          state_d      = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          resp_rdata_d = '0;
          resp_err_d   = 1'b1;
          state_d      = RESP;
        end
      end
      RESP: begin
        resp_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments make every flop sample pre-edge values regardless of order.
    if (!RST) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= '0;
      resp_err_q    <= 1'b0;
      send_flag_q   <= 1'b0;
      send_length_q <= '0;
      send_data_q   <= '0;
      recv_flag_q   <= 1'b0;
      drop_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_err_q    <= resp_err_d;
      send_flag_q   <= send_flag_d;
      send_length_q <= send_length_d;
      send_data_q   <= send_data_d;
      recv_flag_q   <= recv_flag_d;
      drop_count_q  <= drop_count_d;
    end
  end

  // NOTE: the latched request is pure datapath, only read after IDLE loads it, so it needs no reset.
  always_ff @(posedge CLK) begin
    wr_q    <= wr_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    mask_q  <= mask_d;
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;
  assign send_flag   = send_flag_q;
  assign send_length = send_length_q;
  assign send_data   = send_data_q;
  assign recv_flag   = recv_flag_q;
  assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_mem_uart_master.sv
// Self-checking bench for mem_uart_master: directed and random transactions
// against an edge-level transaction model with a queue-based comm channel.
`timescale 1ns/1ps
module tb_mem_uart_master;

  localparam int TIMEOUT = 16;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_mask = '0;
  logic        req_ready, resp_valid, resp_err, send_flag, recv_flag;
  logic [31:0] resp_rdata;
  logic [4:0]  send_length;
  logic [71:0] send_data;
  logic        sendable = 1'b0, recvable = 1'b0;
  logic [4:0]  recv_length = '0;
  logic [71:0] recv_data = '0;
  logic [7:0]  drop_count;

  mem_uart_master #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_mask(req_mask), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .send_flag(send_flag), .send_length(send_length), .send_data(send_data),
    .sendable(sendable), .recv_flag(recv_flag), .recv_length(recv_length),
    .recv_data(recv_data), .recvable(recvable), .drop_count(drop_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  len;
    logic [71:0] data;
  } msg_t;
  msg_t inq[$];

  int n_assert = 0, n_fail = 0;
  // Edge index k = value registered by rising edge k (visible during cycle k+1).
  int cyc = 0;
  int n_acc = 0, n_send = 0, n_resp = 0, n_pop = 0, back2back = 0;
  int acc_edge = -1, send_edge = -1, resp_edge = -1;
  logic [4:0]  send_len_seen;
  logic [71:0] send_data_seen;
  logic [31:0] rdata_seen;
  logic        err_seen;
  int exp_drop = 0;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_recv();
    if (inq.size() > 0) begin
      recvable    = 1'b1;
      recv_length = inq[0].len;
      recv_data   = inq[0].data;
    end else begin
      recvable    = 1'b0;
      recv_length = '0;
      recv_data   = '0;
    end
  endtask

  task automatic push_msg(input logic [4:0] len, input logic [71:0] data);
    msg_t m;
    m.len  = len;
    m.data = data;
    inq.push_back(m);
    drive_recv();
  endtask

  task automatic push_junk(input int jlen);
    int l;
    l = jlen;
    if (l < 0) begin
      l = $urandom_range(0, 30);
      if (l >= 4) l++;
    end
    push_msg(5'(l), {8'($urandom), 32'($urandom), 32'($urandom)});
  endtask

  task automatic add_drop(input int k);
    exp_drop = (exp_drop + k > 255) ? 255 : exp_drop + k;
  endtask

  // One clock edge: the comm channel pops on a sampled recv_flag, then events are logged.
  task automatic tick();
    logic pre_rf, pre_sf, pre_acc;
    pre_rf  = recv_flag;
    pre_sf  = send_flag;
    pre_acc = req_valid && req_ready && RST;
    @(posedge CLK);
    #1;
    cyc++;
    if (pre_rf) begin
      n_pop++;
      if (inq.size() > 0) inq.delete(0);
    end
    if (pre_acc) begin
      n_acc++;
      acc_edge = cyc;
    end
    if (send_flag) begin
      n_send++;
      send_edge      = cyc;
      send_len_seen  = send_length;
      send_data_seen = send_data;
      if (pre_sf) back2back++;
    end
    if (recv_flag && pre_rf) back2back++;
    if (resp_valid) begin
      n_resp++;
      resp_edge  = cyc;
      rdata_seen = resp_rdata;
      err_seen   = resp_err;
    end
    drive_recv();
  endtask

  function automatic logic [71:0] exp_payload(input bit wr, input logic [31:0] a,
                                              input logic [31:0] d, input logic [3:0] m);
    logic [71:0] p;
    p = '0;
    p[31:0] = wr ? d : a;
    if (wr) begin
      p[63:32] = a;
      p[67:64] = m;
    end
    return p;
  endfunction

  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] mask, input int s_delay, input bit reply,
                        input int r_delay, input int n_junk, input int junk_len,
                        input int pre_junk, input logic [31:0] rdata);
    int sb, rb, pb, ab, g, exp_resp, exp_pops;
    logic [31:0] exp_rd;
    logic        exp_err;
    sendable = 1'b0;
    sb = n_send; rb = n_resp; pb = n_pop; ab = n_acc;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_mask = mask;
    g = 0;
    while (n_acc == ab && g < 20) begin tick(); g++; end
    req_valid = 1'b0; req_write = ~wr; req_addr = $urandom; req_wdata = $urandom; req_mask = 4'($urandom);
    check("accepted", n_acc - ab, 1);
    check("ready_busy", req_ready, 1'b0);
    for (int i = 0; i < pre_junk; i++) push_junk(-1);
    add_drop(pre_junk);
    repeat (s_delay) tick();
    check("no_early_send", n_send - sb, 0);
    sendable = 1'b1;
    g = 0;
    while (n_send == sb && g < 50) begin tick(); g++; end
    check("send_count", n_send - sb, 1);
    check("send_edge", send_edge, acc_edge + 1 + s_delay);
    check("send_length", send_len_seen, wr ? 5'd9 : 5'd5);
    check("send_data", send_data_seen, exp_payload(wr, addr, wdata, mask));
    if (wr) begin
      exp_resp = send_edge + 1; exp_rd = '0; exp_err = 1'b0; exp_pops = pre_junk;
    end else begin
      repeat (r_delay) tick();
      for (int j = 0; j < n_junk; j++) push_junk(junk_len);
      add_drop(n_junk);
      if (reply) begin
        push_msg(5'd4, {8'($urandom), 32'($urandom), rdata});
        exp_resp = send_edge + r_delay + 2 + 2 * n_junk;
        exp_rd = rdata; exp_err = 1'b0; exp_pops = pre_junk + n_junk + 1;
      end else begin
        exp_resp = send_edge + TIMEOUT + 1;
        exp_rd = '0; exp_err = 1'b1; exp_pops = pre_junk + n_junk;
      end
    end
    g = 0;
    while (n_resp == rb && g < TIMEOUT + 60) begin tick(); g++; end
    check("resp_seen", n_resp - rb, 1);
    check("resp_edge", resp_edge, exp_resp);
    check("resp_rdata", rdata_seen, exp_rd);
    check("resp_err", err_seen, exp_err);
    repeat (3) tick();
    check("single_resp", n_resp - rb, 1);
    check("pops", n_pop - pb, exp_pops);
    check("drop_count", drop_count, exp_drop);
    check("ready_idle", req_ready, 1'b1);
    if (!wr && !reply) begin
      rb = n_resp;
      push_msg(5'd4, {40'h0, 32'($urandom)});
      add_drop(1);
      repeat (4) tick();
      check("late_reply_drop", drop_count, exp_drop);
      check("late_reply_no_resp", n_resp - rb, 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sb, rb, g, k;
    drive_recv();
    RST = 1'b0;
    repeat (3) tick();
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_send_flag", send_flag, 1'b0);
    check("rst_recv_flag", recv_flag, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_drop_count", drop_count, 8'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_send_data", send_data, 72'd0);
    RST = 1'b1;
    tick();

    do_txn(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0101, 0, 1'b0, 0, 0, -1, 0, '0);
    check("store_payload_const", send_data_seen, 72'h05_0000_1000_DEAD_BEEF);
    check("store_latency", resp_edge - acc_edge, 2);
    do_txn(1'b0, 32'h0000_0004, '0, '0, 0, 1'b1, 5, 0, -1, 0, 32'h1234_5678);
    do_txn(1'b0, 32'h8000_00F0, '0, '0, 10, 1'b1, 5, 0, -1, 0, 32'h0BAD_F00D);
    do_txn(1'b0, 32'h0000_0100, '0, '0, 0, 1'b0, 0, 0, -1, 0, '0);
    do_txn(1'b0, 32'h0000_0200, '0, '0, 0, 1'b1, 3, 1, 9, 0, 32'hCAFE_BABE);
    do_txn(1'b1, 32'hFFFF_FFFC, 32'h0102_0304, 4'b1111, 0, 1'b0, 0, 0, -1, 1, '0);

    for (int t = 0; t < 30; t++) begin
      k = $urandom_range(0, 2);
      do_txn(k == 0, $urandom, $urandom, 4'($urandom), $urandom_range(0, 4), k == 1,
             $urandom_range(1, 6), $urandom_range(0, 2), -1, $urandom_range(0, 1), $urandom);
      k = $urandom_range(0, 2);
      for (int i = 0; i < k; i++) push_junk(-1);
      add_drop(k);
      repeat (2 * k + 2) tick();
    end
    check("random_drop_count", drop_count, exp_drop);

    for (int i = 0; i < 260; i++) push_junk(-1);
    add_drop(260);
    repeat (2 * 260 + 4) tick();
    check("drop_saturate", drop_count, 8'd255);

    sendable = 1'b1;
    sb = n_send;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0300;
    g = 0;
    while (n_send == sb && g < 20) begin tick(); g++; end
    req_valid = 1'b0;
    check("rst_wait_send", n_send - sb, 1);
    repeat (3) tick();
    RST = 1'b0;
    tick();
    RST = 1'b1;
    exp_drop = 0;
    sb = n_send; rb = n_resp;
    check("midrst_ready", req_ready, 1'b1);
    check("midrst_drop", drop_count, 8'd0);
    repeat (TIMEOUT + 5) tick();
    check("midrst_no_resp", n_resp - rb, 0);
    check("midrst_no_send", n_send - sb, 0);
    do_txn(1'b0, 32'h0000_0400, '0, '0, 0, 1'b1, 2, 0, -1, 0, 32'hA5A5_5A5A);

    check("no_back_to_back_flags", back2back, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
